counter_4b_ctrl: RTL and testbench



---
 rtl/counter_4b_ctrl_pkg.sv | 10 +
 rtl/counter_4b_ctrl_if.sv | 21 ++
 rtl/counter_4b_ctrl_tick_gen.sv | 18 +
 rtl/counter_4b_ctrl.sv | 61 ++++++
 tb/tb_counter_4b_ctrl.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/counter_4b_ctrl_pkg.sv
// counter_ctrl_pkg: shared state type, default widths and saturating increment for the counter controller
package counter_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
  localparam int DEF_CNT_W = 4;
  localparam int DEF_PSC_W = 8;
  localparam int DEF_EXP_W = 8;
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    return v == (32'd1 << w) - 32'd1 ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/counter_4b_ctrl_if.sv
// counter_4b_ctrl_if: command inputs and counter-side signals of the timer controller
interface counter_4b_ctrl_if import counter_ctrl_pkg::*; #(
  parameter int CNT_W = DEF_CNT_W,
  parameter int PSC_W = DEF_PSC_W,
  parameter int EXP_W = DEF_EXP_W
);
  logic START, STOP, HOLD, AUTO_RELOAD, DIR, CO_IN;
  logic [CNT_W-1:0] PRESET;
  logic [PSC_W-1:0] PSC;
  logic M, LD, CE, BUSY, DONE;
  logic [CNT_W-1:0] D;
  logic [EXP_W-1:0] EXP_CNT;
  modport master(
    output START, STOP, HOLD, AUTO_RELOAD, DIR, PRESET, PSC, CO_IN,
    input M, LD, CE, D, BUSY, DONE, EXP_CNT
  );
  modport slave(
    input START, STOP, HOLD, AUTO_RELOAD, DIR, PRESET, PSC, CO_IN,
    output M, LD, CE, D, BUSY, DONE, EXP_CNT
  );
endinterface

// File: rtl/counter_4b_ctrl_tick_gen.sv
// tick_gen: prescaler producing one tick every div+1 un-held cycles
module tick_gen #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         hold,
  input  logic [W-1:0] div,
  output logic         tick
);
  logic [W-1:0] cnt;
  assign tick = !clr && !hold && cnt == div;
  // prescale count: cleared outside RUN, frozen on hold, wraps on tick
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (!hold) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/counter_4b_ctrl.sv
// counter_4b_ctrl: timer controller driving a 4-bit up/down counter's M/LD/CE/D from its CO
module counter_4b_ctrl import counter_ctrl_pkg::*; #(
  parameter int CNT_W = DEF_CNT_W,
  parameter int PSC_W = DEF_PSC_W,
  parameter int EXP_W = DEF_EXP_W
) (
  input logic CLK,
  input logic RST,
  counter_4b_ctrl_if.slave bus
);
  state_t state;
  logic dir_r, auto_r, done_r, busy_r;
  logic [CNT_W-1:0] preset_r;
  logic [PSC_W-1:0] psc_r;
  logic [EXP_W-1:0] exp_r;
  logic run, cmd, tick, expiry;
  assign run = state == RUN;
  assign cmd = bus.STOP || bus.START;
  assign expiry = run && tick && bus.CO_IN && !cmd;
  tick_gen #(.W(PSC_W)) u_tick (
    .clk(CLK), .rst(RST), .clr(!run || cmd), .hold(bus.HOLD), .div(psc_r), .tick(tick)
  );
  assign bus.LD = !bus.STOP && (state == LOAD || (expiry && auto_r));
  assign bus.CE = run && tick && !bus.CO_IN && !cmd;
  assign bus.M = dir_r;
  assign bus.D = preset_r;
  assign bus.BUSY = busy_r;
  assign bus.DONE = done_r;
  assign bus.EXP_CNT = exp_r;
  // control FSM: STOP beats START beats expiry; config captured only on accepted START
  always_ff @(posedge CLK)
    if (RST) begin
      state <= IDLE;
      dir_r <= 1'b0;
      auto_r <= 1'b0;
      preset_r <= '0;
      psc_r <= '0;
      exp_r <= '0;
      done_r <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      done_r <= expiry;
      if (expiry) exp_r <= EXP_W'(sat_inc(32'(exp_r), EXP_W));
      if (bus.STOP) begin
        state <= IDLE;
        busy_r <= 1'b0;
      end else if (bus.START) begin
        state <= LOAD;
        busy_r <= 1'b1;
        dir_r <= bus.DIR;
        auto_r <= bus.AUTO_RELOAD;
        preset_r <= bus.PRESET;
        psc_r <= bus.PSC;
        exp_r <= '0;
      end else if (state == LOAD) state <= RUN;
      else if (expiry && !auto_r) begin
        state <= IDLE;
        busy_r <= 1'b0;
      end
    end
endmodule

// File: tb/tb_counter_4b_ctrl.sv
// tb_counter_4b_ctrl: scoreboard bench for the timer controller against a behavioural 4-bit counter
module tb_counter_4b_ctrl;
  typedef struct {int c; logic [7:0] e; logic [3:0] q;} exp_t;
  logic clk = 0, rst = 1;
  int cyc = 0, n_chk = 0, n_err = 0, nb_done = 0, c0;
  logic [3:0] qa = 0, qb = 0;
  exp_t sb[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  counter_4b_ctrl_if #(.CNT_W(4), .PSC_W(8), .EXP_W(8)) a();
  counter_4b_ctrl_if #(.CNT_W(4), .PSC_W(8), .EXP_W(2)) b();
  counter_4b_ctrl #(.CNT_W(4), .PSC_W(8), .EXP_W(8)) dut_a(.CLK(clk), .RST(rst), .bus(a));
  counter_4b_ctrl #(.CNT_W(4), .PSC_W(8), .EXP_W(2)) dut_b(.CLK(clk), .RST(rst), .bus(b));
  always @(posedge clk) qa <= a.LD ? a.D : a.CE ? (a.M ? qa - 4'd1 : qa + 4'd1) : qa;
  always @(posedge clk) qb <= b.LD ? b.D : b.CE ? (b.M ? qb - 4'd1 : qb + 4'd1) : qb;
  assign a.CO_IN = a.M ? qa == 4'd0 : qa == 4'hf;
  assign b.CO_IN = b.M ? qb == 4'd0 : qb == 4'hf;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic start_a(input logic dir, input logic auto, input logic [3:0] pre,
                         input logic [7:0] psc, input int n, input int hx);
    int per = (dir ? int'(pre) + 1 : 16 - int'(pre)) * (int'(psc) + 1);
    exp_t e;
    a.START = 1; a.DIR = dir; a.AUTO_RELOAD = auto; a.PRESET = pre; a.PSC = psc;
    for (int k = 1; k <= n; k++) begin
      e.c = cyc + 2 + k * per + hx;
      e.e = 8'(k);
      e.q = auto ? pre : {4{~dir}};
      sb.push_back(e);
    end
    step();
    a.START = 0; a.PRESET = 4'($urandom); a.PSC = 8'($urandom); a.DIR = ~dir; a.AUTO_RELOAD = ~auto;
  endtask
  always @(negedge clk) begin
    if (b.DONE === 1'b1) nb_done++;
    if (a.DONE === 1'b1) begin
      if (sb.size() == 0) check("done_unexpected", a.DONE, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("done_cyc", cyc, e.c);
        check("done_exp_cnt", a.EXP_CNT, e.e);
        check("done_q", qa, e.q);
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, expected finish within 100000 time units");
    $fatal(1);
  end
  initial begin
    {a.START, a.STOP, a.HOLD, a.AUTO_RELOAD, a.DIR, a.PRESET, a.PSC} = '0;
    {b.START, b.STOP, b.HOLD, b.AUTO_RELOAD, b.DIR, b.PRESET, b.PSC} = '0;
    step(); step();
    @(negedge clk);
    check("rst_outs_a", {a.M, a.LD, a.CE, a.BUSY, a.DONE, a.D, a.EXP_CNT}, 0);
    check("rst_exp_b", b.EXP_CNT, 0);
    step();
    rst = 0;
    step();
    // one-shot down from 3
    start_a(1, 0, 3, 0, 1, 0);
    @(negedge clk);
    check("t1_load", {a.LD, a.CE, a.BUSY, a.D}, {3'b101, 4'd3});
    for (int i = 0; i < 4; i++) begin
      step();
      @(negedge clk);
      check("t1_q", qa, 3 - i);
    end
    check("t1_expiry_ld_ce", {a.LD, a.CE}, 0);
    step();
    @(negedge clk);
    check("t1_busy", a.BUSY, 0);
    check("t1_exp_cnt", a.EXP_CNT, 1);
    repeat (3) step();
    check("t1_q_hold", qa, 0);
    // auto-reload up from 13, prescale 2
    c0 = cyc;
    start_a(0, 1, 13, 1, 5, 0);
    for (int i = 0; i < 30; i++) begin
      step();
      @(negedge clk);
      check("t2_q", qa, 13 + ((cyc - c0 - 2) % 6) / 2);
    end
    step();
    @(negedge clk);
    check("t2_exp_cnt", a.EXP_CNT, 5);
    step();
    a.STOP = 1;
    @(negedge clk);
    check("t2_stop_ld_ce", {a.LD, a.CE}, 0);
    step();
    a.STOP = 0;
    @(negedge clk);
    check("t2_stop_busy", a.BUSY, 0);
    repeat (8) step();
    // hold for three cycles in a down count from 2
    start_a(1, 0, 2, 0, 1, 3);
    step(); step();
    a.HOLD = 1;
    repeat (3) begin
      @(negedge clk);
      check("t3_hold_ce", {a.CE, a.LD}, 0);
      check("t3_hold_q", qa, 1);
      step();
    end
    a.HOLD = 0;
    repeat (4) step();
    // STOP and START together during RUN, colliding with an expiry
    start_a(1, 1, 1, 0, 2, 0);
    repeat (6) step();
    a.STOP = 1; a.START = 1; a.PRESET = 7; a.DIR = 0;
    @(negedge clk);
    check("t4_stop_ld_ce", {a.LD, a.CE}, 0);
    step();
    a.STOP = 0; a.START = 0;
    @(negedge clk);
    check("t4_busy", a.BUSY, 0);
    check("t4_exp_cnt", a.EXP_CNT, 2);
    check("t4_cfg_kept", {a.M, a.D}, {1'b1, 4'd1});
    repeat (4) step();
    start_a(1, 0, 9, 0, 1, 0);
    @(negedge clk);
    check("t4_load9", {a.LD, a.D, a.EXP_CNT}, {1'b1, 4'd9, 8'd0});
    repeat (13) step();
    // restart coinciding with an expiry
    start_a(1, 1, 2, 0, 2, 0);
    repeat (9) step();
    start_a(0, 0, 6, 0, 1, 0);
    @(negedge clk);
    check("t5_restart", {a.LD, a.CE, a.M, a.D, a.EXP_CNT}, {3'b100, 4'd6, 8'd0});
    repeat (12) step();
    // 2-bit expiry counter saturates, then reset mid-run
    b.START = 1; b.DIR = 1; b.AUTO_RELOAD = 1; b.PRESET = 1; b.PSC = 0;
    step();
    b.START = 0; b.PRESET = 5; b.DIR = 0;
    repeat (7) step();
    @(negedge clk);
    check("t6_exp_3", b.EXP_CNT, 3);
    repeat (4) step();
    @(negedge clk);
    check("t6_exp_sat", b.EXP_CNT, 3);
    step();
    rst = 1;
    @(negedge clk);
    check("t6_done_count", nb_done, 5);
    check("t6_busy_pre_rst", b.BUSY, 1);
    step();
    rst = 0;
    @(negedge clk);
    check("t6_rst_outs", {b.M, b.LD, b.CE, b.BUSY, b.DONE, b.D, b.EXP_CNT}, 0);
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
